preset_sequencer: RTL
=====================

Name: preset_sequencer

Overview:
- Driver for the asynchronous set/reset inputs of a bank of set/reset D flip-flops. It preloads a known bit pattern into the bank without using the data path.
- On a start strobe it captures an init word. It then walks the bank one bit at a time and issues a clean rising-edge pulse on that bit's set line (bit = 1) or reset line (bit = 0).
- Sits between the processor's power-on/control logic and the register/state flip-flop bank.

Parameters:
- WIDTH, 8, number of flip-flops driven (>= 1).
- PULSE_CYCLES, 2, clock cycles each set/reset pulse is held high (>= 1).
- GAP_CYCLES, 1, clock cycles all s/r lines are held low between pulses (>= 1). Guarantees a fresh posedge per bit.
- IDX_W, $clog2(WIDTH) (min 1), width of bit_idx.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a preload sequence; sampled only in IDLE.
- abort  input  1  synchronous abort of an in-progress sequence.
- init_value  input  WIDTH  pattern to preload; captured on the accepted start edge.
- s_out  output  WIDTH  per-bit set pulses to the flip-flop bank.
- r_out  output  WIDTH  per-bit reset pulses to the flip-flop bank.
- busy  output  1  high while a sequence is in progress.
- done  output  1  one-cycle pulse on successful completion.
- bit_idx  output  IDX_W  index of the bit currently being pulsed or gapped.

Behaviour:
- Reset:
  - rst_n low immediately (asynchronously) forces state IDLE.
  - Forces s_out = 0, r_out = 0, busy = 0, done = 0, bit_idx = 0, captured word = 0 and cycle counter = 0.
  - Reset asserted mid-sequence abandons the sequence with no done. Any s/r pulse in flight drops at once.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE: all outputs low. On the edge where start = 1, capture init_value, set bit_idx = 0 and cnt = 0, then go to PULSE.
  - PULSE:
    - s_out[bit_idx] = captured[bit_idx]; r_out[bit_idx] = ~captured[bit_idx]; all other s/r bits 0.
    - Exactly one of the 2*WIDTH lines is high.
    - Stays PULSE_CYCLES cycles, then goes to GAP with cnt = 0.
  - GAP:
    - All s/r lines 0 for GAP_CYCLES cycles.
    - Then, if bit_idx = WIDTH-1, go to DONE; else increment bit_idx and go to PULSE.
  - DONE: done = 1 and busy = 0 for exactly one cycle, s/r = 0, bit_idx = 0. Next state is IDLE.
- Timing:
  - busy = 1 in PULSE and GAP, rising in the cycle after the accepted start edge.
  - The first pulse begins the cycle after the start edge (latency 1).
  - busy lasts exactly WIDTH*(PULSE_CYCLES+GAP_CYCLES) cycles, immediately followed by the done cycle.
- start:
  - start while busy or in DONE is ignored (not queued).
  - start held continuously re-triggers only from IDLE, so the minimum restart spacing is one IDLE cycle after done.
  - init_value changes after capture have no effect.
- abort:
  - Sampled in PULSE or GAP.
  - Next edge: s/r = 0, busy = 0, bit_idx = 0, state IDLE, no done.
  - Flip-flops already pulsed keep their values; the remaining bits are untouched.
  - abort in IDLE or DONE has no effect. abort and start together in IDLE: abort has no effect and start is accepted.
- Counter width: cnt must be wide enough for max(PULSE_CYCLES, GAP_CYCLES)-1. bit_idx never exceeds WIDTH-1.

Test Plan:
- WIDTH=4, P=2, G=1; start with init_value=4'b1010
  -> pulses r0, s1, r2, s3 in order, each 2 cycles high with a 1-cycle all-low gap.
  -> busy high for 12 cycles; done high on cycle 13 after start; a 4-bit dfff bank reads 1010.
- Reset mid-pulse: assert rst_n=0 while s_out[1]=1
  -> s_out/r_out/busy drop without waiting for a clock edge; after release, state is IDLE with done never asserted.
- start pulsed again on cycles 3 and 7 of a running sequence
  -> ignored; exactly one done; total busy still 12.
- abort during GAP after bit 1
  -> next edge busy=0, all s/r 0, no done; bank bits 0–1 are updated, bits 2–3 keep their prior values.
- Pulse-shape check: each cycle assert popcount(s_out|r_out) <= 1 and never (s_out[i] & r_out[i]).
  -> every bit sees a 0→1 transition on exactly one line per sequence.
- WIDTH=1, P=1, G=1; start with init_value=1
  -> s_out[0] high 1 cycle, gap 1 cycle, done on cycle 3; start held high gives the next sequence starting after one IDLE cycle.

Source files
------------

// File: rtl/preset_sequencer.sv
// Preload sequencer: walks a captured init word bit by bit, pulsing each bit's set or reset line.
// Latency: first pulse appears the cycle after the accepted start; done follows WIDTH*(PULSE+GAP) busy cycles.
// Backpressure: none; start is honoured only in IDLE, and abort returns to IDLE on the next edge.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   start, abort   - begin a preload (IDLE only) / abandon one in progress (PULSE/GAP only)
//   init_value     - pattern captured on the accepted start edge
//   s_out, r_out   - per-bit set/reset pulses to the flip-flop bank (at most one line high)
//   busy, done     - sequence in progress / one-cycle completion strobe
//   bit_idx        - bit currently being pulsed or gapped
module preset_sequencer #(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int IDX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] init_value,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] bit_idx
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] P_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cap, cap_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx_n;
  logic [WIDTH-1:0] onehot, s_n, r_n;
  logic             busy_n, done_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cap     <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      s_out   <= '0;
      r_out   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cap     <= cap_n;
      cnt     <= cnt_n;
      bit_idx <= idx_n;
      s_out   <= s_n;
      r_out   <= r_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Outputs are decoded from the *next* state so that every output is a
  // flop, yet the first pulse still lands in the cycle right after start.
  always_comb begin
    state_n = state;
    cap_n   = cap;
    cnt_n   = cnt;
    idx_n   = bit_idx;

    case (state)
      S_IDLE: begin
        if (start) begin
          cap_n   = init_value;
          cnt_n   = '0;
          idx_n   = '0;
          state_n = S_PULSE;
        end
      end
      S_PULSE: begin
        if (abort) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = S_IDLE;
        end else if (cnt == P_LAST) begin
          cnt_n   = '0;
          state_n = S_GAP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = S_IDLE;
        end else if (cnt == G_LAST) begin
          cnt_n = '0;
          if (bit_idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = S_DONE;
          end else begin
            idx_n   = bit_idx + 1'b1;
            state_n = S_PULSE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    onehot        = '0;
    onehot[idx_n] = 1'b1;
    s_n    = (state_n == S_PULSE) ? (onehot &  cap_n) : '0;
    r_n    = (state_n == S_PULSE) ? (onehot & ~cap_n) : '0;
    busy_n = (state_n == S_PULSE) || (state_n == S_GAP);
    done_n = (state_n == S_DONE);
  end

endmodule
